// File: rtl/secuencia_control.sv
// Multi-cycle instruction sequencer for the bam register-file/ALU/RAM stage.
// Fetch, decode and execute take one cycle each; cu_* strobes are decoded from state and IR.
module secuencia_control #(
    parameter int unsigned     PC_W     = 8,
    parameter logic [PC_W-1:0] START_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_data,
    input  logic            zf_in,
    output logic [4:0]      cu_ra1,
    output logic [4:0]      cu_ra2,
    output logic [2:0]      cu_sel,
    output logic [4:0]      cu_dirb,
    output logic [31:0]     cu_di,
    output logic            cu_reg_write,
    output logic [4:0]      cu_dir,
    output logic            cu_wr,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted,
    output logic            illegal
);

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, HALT} stateT;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LI    = 6'h08;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    stateT       state;
    logic [31:0] ir;
    logic [5:0]  opCode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [2:0]  aluSel;
    logic        functOk;
    logic        legal;

    assign opCode = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign funct  = ir[5:0];
    assign imm    = ir[15:0];

    assign imem_addr = pc;
    assign busy      = (state == FETCH) || (state == DECODE) || (state == EXECUTE);
    assign halted    = (state == HALT);

    always_comb begin
        functOk = 1'b1;
        aluSel  = '0;
        case (funct)
            6'h20:   aluSel = 3'b000;
            6'h22:   aluSel = 3'b001;
            6'h24:   aluSel = 3'b010;
            6'h25:   aluSel = 3'b011;
            6'h2A:   aluSel = 3'b100;
            default: functOk = 1'b0;
        endcase
        legal = (opCode == OP_LI) || (opCode == OP_BEQ) || (opCode == OP_HALT)
             || ((opCode == OP_RTYPE) && functOk);
    end

    always_comb begin
        cu_ra1       = '0;
        cu_ra2       = '0;
        cu_sel       = '0;
        cu_dirb      = '0;
        cu_di        = '0;
        cu_reg_write = 1'b0;
        cu_dir       = '0;
        cu_wr        = 1'b0;
        if (state == EXECUTE) begin
            case (opCode)
                OP_RTYPE: begin
                    if (functOk) begin
                        cu_ra1 = rs;
                        cu_ra2 = rt;
                        cu_sel = aluSel;
                        cu_dir = rd;
                        cu_wr  = 1'b1;
                    end
                end
                OP_LI: begin
                    cu_dirb      = rt;
                    cu_di        = {{16{imm[15]}}, imm};
                    cu_reg_write = 1'b1;
                end
                OP_BEQ: begin
                    cu_ra1 = rs;
                    cu_ra2 = rt;
                    cu_sel = 3'b001;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= START_PC;
            ir      <= '0;
            illegal <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (start) state <= FETCH;
                FETCH:   state <= DECODE;
                DECODE: begin
                    ir    <= imem_data;
                    state <= EXECUTE;
                end
                EXECUTE: begin
                    if (opCode == OP_HALT) begin
                        state <= HALT;
                    end else begin
                        state <= FETCH;
                        if (!legal) illegal <= 1'b1;
                        // Branch offset is the low PC_W bits of imm; the sum wraps.
                        if ((opCode == OP_BEQ) && zf_in)
                            pc <= pc + PC_W'(1) + PC_W'(imm);
                        else
                            pc <= pc + PC_W'(1);
                    end
                end
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
